// File: rtl/rr_fifo_router.sv
// Round-robin router: pops one word at a time from NUM_PORTS input FIFOs and
// pushes it to the output FIFO named by its destination field, holding it under back-pressure.
module rr_fifo_router #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_PORTS  = 4,
  parameter int DEST_LSB   = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [NUM_PORTS-1:0]            in_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            pop,
  input  logic [NUM_PORTS-1:0]            out_pause,
  input  logic [NUM_PORTS-1:0]            out_full,
  output logic [NUM_PORTS-1:0]            push,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [1:0]                      active_port,
  output logic                            idle,
  output logic                            err_underflow,
  output logic [CNT_WIDTH-1:0]            word_count
);

  typedef enum logic [2:0] {ARB, POP, CAPT, WAIT, PUSH} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [NUM_PORTS-1:0]    r_pop;
  logic [NUM_PORTS-1:0]    r_push;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [1:0]              r_active_port;
  logic                    r_idle;
  logic                    r_err_underflow;
  logic [CNT_WIDTH-1:0]    r_word_count;

  logic                    w_grant_valid;
  logic [1:0]              w_grant_port;
  logic [1:0]              w_dest;
  logic                    w_dest_ready;
  logic [DATA_WIDTH-1:0]   w_in_slice;

  assign w_dest       = r_hold[DEST_LSB+1:DEST_LSB];
  assign w_dest_ready = !out_pause[w_dest] && !out_full[w_dest];
  assign w_in_slice   = in_data[int'(r_active_port)*DATA_WIDTH +: DATA_WIDTH];

  // Search downward so the nearest port after the last grant wins; the
  // just-served port (offset NUM_PORTS wraps to itself) is considered last.
  always_comb begin
    logic [1:0] v_idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_grant_valid = 1'b0;
    w_grant_port  = r_active_port;
    v_idx         = r_active_port;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      v_idx = r_active_port + 2'(k);
      if (!in_empty[v_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_port  = v_idx;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB:     if (w_grant_valid) w_next_state = POP;
      POP:     w_next_state = in_empty[r_active_port] ? ARB : CAPT;
      CAPT:    w_next_state = WAIT;
      WAIT:    if (w_dest_ready) w_next_state = PUSH;
      PUSH:    w_next_state = ARB;
      default: w_next_state = ARB;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state         <= ARB;
      r_pop           <= '0;
      r_push          <= '0;
      r_hold          <= '0;
      r_out_data      <= '0;
      r_active_port   <= 2'(NUM_PORTS - 1);
      r_idle          <= 1'b1;
      r_err_underflow <= 1'b0;
      r_word_count    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      r_state <= w_next_state;
      r_idle  <= (w_next_state == ARB);
      r_pop   <= (w_next_state == POP) ? (NUM_PORTS'(1) << w_grant_port) : '0;
      r_push  <= (w_next_state == PUSH) ? (NUM_PORTS'(1) << w_dest) : '0;
      if (r_state == ARB && w_grant_valid) r_active_port <= w_grant_port;
      if (r_state == POP && in_empty[r_active_port]) r_err_underflow <= 1'b1;
      if (r_state == CAPT) r_hold <= w_in_slice;
      if (w_next_state == PUSH) begin
        r_out_data   <= r_hold;
        r_word_count <= r_word_count + CNT_WIDTH'(1);
      end
    end
  end

  assign pop           = r_pop;
  assign push          = r_push;
  assign out_data      = r_out_data;
  assign active_port   = r_active_port;
  assign idle          = r_idle;
  assign err_underflow = r_err_underflow;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_rr_fifo_router.sv
// Directed bench for rr_fifo_router: single word, round robin, reset, back-pressure,
// underflow and counter wrap, each checked against hand-computed values.
module tb_rr_fifo_router;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  in_empty;
  logic [23:0] in_data;
  logic [3:0]  pop;
  logic [3:0]  out_pause;
  logic [3:0]  out_full;
  logic [3:0]  push;
  logic [5:0]  out_data;
  logic [1:0]  active_port;
  logic        idle;
  logic        err_underflow;
  logic [7:0]  word_count;

  int n_tests = 0;
  int n_fail  = 0;

  rr_fifo_router dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .in_empty      (in_empty),
    .in_data       (in_data),
    .pop           (pop),
    .out_pause     (out_pause),
    .out_full      (out_full),
    .push          (push),
    .out_data      (out_data),
    .active_port   (active_port),
    .idle          (idle),
    .err_underflow (err_underflow),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L   = 1'b0;
    in_empty  = 4'b1111;
    in_data   = '0;
    out_pause = '0;
    out_full  = '0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pop_val [8];
    int         pop_cyc [8];
    logic [3:0] push_val [8];
    logic [5:0] push_dat [8];
    logic [3:0] exp_push [4];
    logic [5:0] exp_dat  [4];
    int         np, nq, overlap, acc, pushes;
    bit         done;

    // ---------------- Single word ----------------
    do_reset();
    check("rst_idle", idle, 1);
    check("rst_active_port", active_port, 3);
    in_data  = {18'h0, 6'b10_0101};
    in_empty = 4'b1110;
    tick();
    check("single_pop", pop, 4'b0001);
    check("single_active", active_port, 0);
    check("single_busy", idle, 0);
    tick();
    in_empty = 4'b1111;
    check("single_pop_once", pop, 4'b0000);
    tick();
    check("single_no_push_capt", push, 4'b0000);
    tick();
    check("single_push", push, 4'b0100);
    check("single_data", out_data, 6'h25);
    check("single_count", word_count, 1);
    tick();
    check("single_push_once", push, 4'b0000);
    check("single_idle", idle, 1);
    check("single_data_hold", out_data, 6'h25);

    // ---------------- Round robin + mid-stream reset ----------------
    do_reset();
    in_data  = {6'h04, 6'h33, 6'h22, 6'h11};
    exp_push = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat  = '{6'h11, 6'h22, 6'h33, 6'h04};
    in_empty = 4'b0000;
    np = 0; nq = 0; overlap = 0;
    for (int cyc = 0; cyc < 40 && np < 5; cyc++) begin
      tick();
      if (pop != 0 && push != 0) overlap++;
      if (pop != 0) begin pop_val[np] = pop; pop_cyc[np] = cyc; np++; end
      if (push != 0 && nq < 8) begin push_val[nq] = push; push_dat[nq] = out_data; nq++; end
    end
    check("rr_grants", np, 5);
    check("rr_pushes", nq, 4);
    check("rr_no_overlap", overlap, 0);
    for (int i = 0; i < np; i++) begin
      check($sformatf("rr_grant%0d", i), pop_val[i], 4'b0001 << (i % 4));
      if (i > 0) check($sformatf("rr_period%0d", i), pop_cyc[i] - pop_cyc[i-1], 5);
    end
    for (int i = 0; i < nq; i++) begin
      check($sformatf("rr_push%0d", i), push_val[i], exp_push[i]);
      check($sformatf("rr_data%0d", i), push_dat[i], exp_dat[i]);
    end
    check("rr_count", word_count, 4);
    reset_L = 1'b0;
    #1;
    check("rst_mid_pop", pop, 0);
    check("rst_mid_push", push, 0);
    check("rst_mid_idle", idle, 1);
    check("rst_mid_count", word_count, 0);
    check("rst_mid_active", active_port, 3);
    check("rst_mid_data", out_data, 0);
    @(posedge clk);
    #1 reset_L = 1'b1;

    // ---------------- Back-pressure ----------------
    do_reset();
    in_data   = {18'h0, 6'h1A};
    out_pause = 4'b0010;
    in_empty  = 4'b1110;
    tick();
    check("bp_pop", pop, 4'b0001);
    tick();
    in_empty = 4'b1111;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc += int'(pop != 0) + int'(push != 0);
    end
    check("bp_pause_quiet", acc, 0);
    check("bp_busy", idle, 0);
    out_pause = 4'b0000;
    out_full  = 4'b0010;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc += int'(pop != 0) + int'(push != 0);
    end
    check("bp_full_quiet", acc, 0);
    out_full = 4'b0000;
    tick();
    check("bp_push", push, 4'b0010);
    check("bp_data", out_data, 6'h1A);
    tick();
    check("bp_push_once", push, 0);
    check("bp_idle", idle, 1);

    // ---------------- Underflow ----------------
    do_reset();
    in_empty = 4'b1011;
    tick();
    check("uf_pop", pop, 4'b0100);
    check("uf_active", active_port, 2);
    check("uf_err_clear", err_underflow, 0);
    in_empty = 4'b1111;
    tick();
    check("uf_err_set", err_underflow, 1);
    check("uf_back_arb", idle, 1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc += int'(push != 0) + int'(pop != 0);
    end
    check("uf_no_push", acc, 0);
    check("uf_err_sticky", err_underflow, 1);
    check("uf_count", word_count, 0);

    // ---------------- Counter wrap ----------------
    do_reset();
    in_data  = {6'h04, 6'h33, 6'h22, 6'h11};
    in_empty = 4'b0000;
    pushes = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      tick();
      if (push != 0) begin
        pushes++;
        if (pushes == 255) check("wrap_255", word_count, 255);
        if (pushes == 256) begin
          check("wrap_0", word_count, 0);
          done = 1'b1;
        end
      end
    end
    check("wrap_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
